// File: rtl/fb_stream_reader.sv
// -----------------------------------------------------------------------------
// fb_stream_reader
//   Scans a WIDTH x HEIGHT frame out of a synchronous-read frame buffer and
//   emits it as a ready/valid pixel stream, one pixel per beat, with SOP on
//   address 0 and EOP on the last address. Reads are only issued when the
//   output FIFO is guaranteed to have room for them, so the FIFO never
//   overflows and the sink may stall at any time.
//
//   Optional feature macro: FB_READER_PATTERN_EN
//     Defined   -> extra input pattern_en; when latched high at the start of a
//                  frame, pixel data is replaced by 8 vertical colour bars.
//     Undefined -> pixel data always comes from rd_data.
//
// Ports
//   clk        : single clock
//   reset      : synchronous, active-high
//   enable     : level, frames run while high (a started frame always completes)
//   rd_addr    : frame buffer read address (registered)
//   rd_data    : frame buffer data, RD_LAT cycles after rd_addr, ch0 in MSBs
//   src_valid  : beat valid
//   src_ready  : sink ready (ready latency 0)
//   src_data   : expanded pixel, ch0 in MSBs
//   src_sop    : first pixel of frame
//   src_eop    : last pixel of frame
//   frame_done : one-cycle pulse the cycle after the EOP beat is accepted
//   busy       : high while a frame is being read or drained
//   pattern_en : (FB_READER_PATTERN_EN only) colour-bar test pattern select
// -----------------------------------------------------------------------------
module fb_stream_reader #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int CH         = 3,
  parameter int CW_IN      = 4,
  parameter int CW_OUT     = 10,
  parameter int ADDR_W     = 17,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [CH*CW_IN-1:0]    rd_data,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic [CH*CW_OUT-1:0]   src_data,
  output logic                   src_sop,
  output logic                   src_eop,
  output logic                   frame_done,
  output logic                   busy
`ifdef FB_READER_PATTERN_EN
  ,
  input  logic                   pattern_en
`endif
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW    = CH * CW_OUT;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
`ifdef FB_READER_PATTERN_EN
    logic       pat;
    logic [2:0] bar;
`endif
  } tag_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } entry_t;

  state_t            state_q, state_d;
  logic              issue;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              last_pix;

  tag_t              tag_new;
  tag_t              tag_in [RD_LAT];
  tag_t              tag_q  [RD_LAT];
  tag_t              tag_out;
  logic              push;
  logic              pop;
  logic [DW-1:0]     wr_data;

  entry_t            fifo_mem [FIFO_DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, inflight_q;
  logic              frame_done_q;

  // Outstanding reads plus buffered pixels may never exceed FIFO capacity.
  logic [CNT_W:0]    occupancy;
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
  assign last_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (issue && last_pix && !enable) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0 && inflight_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q != S_IDLE);
    issue     = (state_q == S_RUN) && (occupancy < DEPTH_C);
    src_valid = (count_q != '0);
  end

  // Raster counters. Addresses are row-major, so the address itself is just a
  // running counter that wraps together with the row/col counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      rd_addr_q <= '0;
    end else if (issue) begin
      if (last_pix) begin
        col_q     <= '0;
        row_q     <= '0;
        rd_addr_q <= '0;
      end else begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  assign rd_addr = rd_addr_q;

`ifdef FB_READER_PATTERN_EN
  // Pattern select is latched with address 0 so a frame is never mixed.
  logic        pat_frame_q;
  logic        pat_now;
  logic [31:0] bar_full;
  assign pat_now  = (rd_addr_q == '0) ? pattern_en : pat_frame_q;
  assign bar_full = (32'(col_q) << 3) / 32'(WIDTH);

  always_ff @(posedge clk) begin
    if (reset)                          pat_frame_q <= 1'b0;
    else if (issue && rd_addr_q == '0)  pat_frame_q <= pattern_en;
  end
`endif

  always_comb begin
    tag_new     = '0;
    tag_new.vld = issue;
    tag_new.sop = (rd_addr_q == '0);
    tag_new.eop = last_pix;
`ifdef FB_READER_PATTERN_EN
    tag_new.pat = pat_now;
    tag_new.bar = bar_full[2:0];
`endif
  end

  // Tag shift register, aligned with the frame buffer read latency.
  genvar gi, gj;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        assign tag_in[gi] = tag_new;
      end else begin : g_next
        assign tag_in[gi] = tag_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (reset) tag_q[i] <= '0;
      else       tag_q[i] <= tag_in[i];
    end
  end

  assign tag_out = tag_q[RD_LAT-1];
  assign push    = tag_out.vld;

  // Per-channel width conversion: replicate MSB-first, truncate to CW_OUT.
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [CW_IN-1:0]  ch_in;
      logic [CW_OUT-1:0] ch_exp;
      assign ch_in = rd_data[(CH-1-gi)*CW_IN +: CW_IN];
      for (gj = 0; gj < CW_OUT; gj++) begin : g_bit
        assign ch_exp[CW_OUT-1-gj] = ch_in[CW_IN-1-(gj % CW_IN)];
      end
`ifdef FB_READER_PATTERN_EN
      logic ch_on;
      if (CH - 1 - gi < 3) begin : g_bar
        assign ch_on = tag_out.bar[CH-1-gi];
      end else begin : g_nobar
        assign ch_on = 1'b0;
      end
      assign wr_data[(CH-1-gi)*CW_OUT +: CW_OUT] = tag_out.pat ? {CW_OUT{ch_on}} : ch_exp;
`else
      assign wr_data[(CH-1-gi)*CW_OUT +: CW_OUT] = ch_exp;
`endif
    end
  endgenerate

  // ---------------- Output FIFO ----------------
  assign head = fifo_mem[rd_ptr_q];
  assign pop  = src_valid && src_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{sop: tag_out.sop, eop: tag_out.eop, data: wr_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
      frame_done_q <= pop && head.eop;
    end
  end

  assign src_data   = head.data;
  assign src_sop    = head.sop;
  assign src_eop    = head.eop;
  assign frame_done = frame_done_q;

endmodule
